vid_fmt_sequencer: RTL and testbench

- Pixel-clock-domain controller that sequences video format changes between the register bank and the HDMI timing generator / stream bridge.
- Accepts a requested format code, waits for a frame boundary, and blanks the output.
- Holds the timing generator while the format code is switched, then waits for the configured number of settle frames before releasing the output.
- Prevents torn frames and mid-line timing jumps on the TMDS output when software rewrites the format register.

---
 rtl/vid_fmt_pkg.sv | 27 ++
 rtl/vid_edge_det.sv | 21 ++
 rtl/vid_fmt_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_vid_fmt_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_fmt_pkg.sv
// Shared types for the video format sequencer: format codes, FSM states and a legality helper.
package vid_fmt_pkg;

   localparam int FMT_W = 3;

   typedef logic [FMT_W-1:0] fmt_t;

   localparam fmt_t FMT_720P60  = 3'd0;
   localparam fmt_t FMT_1080P30 = 3'd1;
   localparam fmt_t FMT_1080P60 = 3'd2;
   localparam fmt_t FMT_480P60  = 3'd3;
   localparam fmt_t FMT_576P50  = 3'd4;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      WAIT_VB,
      BLANK,
      APPLY,
      SETTLE
   } state_t;

   function automatic logic fmt_legal(input fmt_t code, input fmt_t max_code);
      return code <= max_code;
   endfunction

endpackage

// File: rtl/vid_edge_det.sv
// Registered rising-edge detector; rise is high for one cycle, one cycle after sig is first seen high.
module vid_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sig_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_d <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sig_d <= sig;
         rise  <= sig & ~sig_d;
      end
   end

endmodule

// File: rtl/vid_fmt_sequencer.sv
// Sequences format changes onto the VTG at frame boundaries with blanking, hold and settle frames.
// Optional WAIT_VB/INIT/SETTLE timeout and sticky tmo_flag port: define VID_FMT_SEQ_TIMEOUT_EN.
module vid_fmt_sequencer
   import vid_fmt_pkg::*;
#(
   parameter fmt_t        FMT_MAX    = 3'd4,
   parameter fmt_t        FMT_RST    = 3'd0,
   parameter int          HOLD_CYC   = 16,
   parameter int          SETTLE_FRM = 2,
   parameter logic [23:0] TMO_CYC    = 24'd4_000_000
) (
   input  logic clk,
   input  logic rst,
   input  fmt_t fmt_req,
   input  logic vblank,
   input  logic vsync,
   output fmt_t fmt_def,
   output logic vtg_hold,
   output logic out_blank,
   output logic flush,
   output logic busy,
   output logic sw_done,
`ifdef VID_FMT_SEQ_TIMEOUT_EN
   output logic tmo_flag,
`endif
   output logic sw_err
);

   state_t     state, state_nxt;
   fmt_t       fmt_s1, fmt_s2, fmt_s3;
   fmt_t       pend_fmt, pend_nxt, fmt_def_nxt;
   logic [7:0] hold_cnt;
   logic [3:0] settle_cnt;
   logic       vb_rise, vs_rise, tmo_hit, err_lock, err_fire;
   logic       vtg_hold_nxt, out_blank_nxt, flush_nxt, sw_done_nxt;
   logic       req_stable, req_new, req_legal, settle_done, vb_evt;

   vid_edge_det u_vb_edge (.clk(clk), .rst(rst), .sig(vblank), .rise(vb_rise));
   vid_edge_det u_vs_edge (.clk(clk), .rst(rst), .sig(vsync),  .rise(vs_rise));

   // Two-flop synchroniser plus one stability stage for the quasi-static request code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fmt_s1 <= FMT_RST;
         fmt_s2 <= FMT_RST;
         fmt_s3 <= FMT_RST;
      end else begin
         fmt_s1 <= fmt_req;
         fmt_s2 <= fmt_s1;
         fmt_s3 <= fmt_s2;
      end
   end

   assign req_stable = (fmt_s2 == fmt_s3);
   assign req_new    = req_stable && (fmt_s2 != fmt_def);
   assign req_legal  = fmt_legal(fmt_s2, FMT_MAX);

`ifdef VID_FMT_SEQ_TIMEOUT_EN
   logic [23:0] tmo_cnt;
   logic        tmo_run;

   assign tmo_run = (state == INIT) || (state == WAIT_VB) || (state == SETTLE);
   assign tmo_hit = tmo_run && (tmo_cnt == TMO_CYC - 24'd1);

   // Timeout counter restarts on every state change and only runs while waiting on VTG edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt  <= 24'd0;
         tmo_flag <= 1'b0;
      end else begin
         if (!tmo_run || state_nxt != state) tmo_cnt <= 24'd0;
         else if (tmo_cnt != 24'hFF_FFFF)    tmo_cnt <= tmo_cnt + 24'd1;
         if (tmo_hit) tmo_flag <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign vb_evt      = vb_rise | tmo_hit;
   assign settle_done = (vs_rise && settle_cnt == 4'(SETTLE_FRM - 1)) || tmo_hit;

   always_comb begin
      state_nxt     = state;
      pend_nxt      = pend_fmt;
      fmt_def_nxt   = fmt_def;
      vtg_hold_nxt  = vtg_hold;
      out_blank_nxt = out_blank;
      flush_nxt     = 1'b0;
      sw_done_nxt   = 1'b0;
      err_fire      = 1'b0;
      case (state)
         INIT: begin
            if (settle_done) begin
               state_nxt     = IDLE;
               out_blank_nxt = 1'b0;
               vtg_hold_nxt  = 1'b0;
            end
         end
         IDLE: begin
            if (req_new) begin
               if (req_legal) begin
                  state_nxt = WAIT_VB;
                  pend_nxt  = fmt_s2;
               end else begin
                  err_fire = !err_lock;
               end
            end
         end
         WAIT_VB: begin
            // A request that falls back to the live format cancels the switch silently.
            if (req_stable && fmt_s2 == fmt_def) begin
               state_nxt = IDLE;
            end else begin
               if (req_new && req_legal) pend_nxt = fmt_s2;
               if (vb_evt) begin
                  state_nxt     = BLANK;
                  out_blank_nxt = 1'b1;
                  flush_nxt     = 1'b1;
               end
            end
         end
         BLANK: begin
            state_nxt    = APPLY;
            fmt_def_nxt  = pend_fmt;
            vtg_hold_nxt = 1'b1;
         end
         APPLY: begin
            if (hold_cnt == 8'(HOLD_CYC - 1)) begin
               state_nxt    = SETTLE;
               vtg_hold_nxt = 1'b0;
            end
         end
         SETTLE: begin
            if (settle_done) begin
               state_nxt     = IDLE;
               out_blank_nxt = 1'b0;
               sw_done_nxt   = 1'b1;
               if (req_new && !req_legal) err_fire = !err_lock;
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   // State, outputs and saturating counters; counters clear whenever the state is about to change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= INIT;
         pend_fmt   <= FMT_RST;
         fmt_def    <= FMT_RST;
         vtg_hold   <= 1'b1;
         out_blank  <= 1'b1;
         flush      <= 1'b0;
         busy       <= 1'b1;
         sw_done    <= 1'b0;
         sw_err     <= 1'b0;
         err_lock   <= 1'b0;
         hold_cnt   <= 8'd0;
         settle_cnt <= 4'd0;
      end else begin
         state     <= state_nxt;
         pend_fmt  <= pend_nxt;
         fmt_def   <= fmt_def_nxt;
         vtg_hold  <= vtg_hold_nxt;
         out_blank <= out_blank_nxt;
         flush     <= flush_nxt;
         busy      <= (state_nxt != IDLE);
         sw_done   <= sw_done_nxt;
         sw_err    <= err_fire;
         if (err_fire)        err_lock <= 1'b1;
         else if (!req_stable) err_lock <= 1'b0;
         if (state_nxt != state) begin
            hold_cnt   <= 8'd0;
            settle_cnt <= 4'd0;
         end else begin
            if (state == APPLY && hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
            if ((state == INIT || state == SETTLE) && vs_rise && settle_cnt != 4'hF)
               settle_cnt <= settle_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_vid_fmt_sequencer.sv
// Randomised self-checking bench for vid_fmt_sequencer against a transaction-level format-switch model.
module tb_vid_fmt_sequencer;
   import vid_fmt_pkg::*;

   localparam int FRAME    = 300;
   localparam int VB_START = 240;
   localparam int VS_START = 250;
   localparam int VS_LEN   = 4;
   localparam int HOLD     = 16;
   localparam int SETTLE_N = 2;
   localparam int MAX_LEGAL = 4;

   logic clk = 1'b0;
   logic rst;
   fmt_t fmt_req;
   logic vblank, vsync;
   fmt_t fmt_def;
   logic vtg_hold, out_blank, flush, busy, sw_done, sw_err;
`ifdef VID_FMT_SEQ_TIMEOUT_EN
   logic tmo_flag;
`endif

   vid_fmt_sequencer dut (
      .clk(clk), .rst(rst), .fmt_req(fmt_req), .vblank(vblank), .vsync(vsync),
      .fmt_def(fmt_def), .vtg_hold(vtg_hold), .out_blank(out_blank), .flush(flush),
      .busy(busy), .sw_done(sw_done),
`ifdef VID_FMT_SEQ_TIMEOUT_EN
      .tmo_flag(tmo_flag),
`endif
      .sw_err(sw_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_mis = 0;
   int cyc = 0, fcnt = 0, vs_rise_cnt = 0, vb_rise_cyc = 0;
   int n_flush = 0, n_done = 0, n_err = 0, n_blank = 0;
   int flush_cyc = 0, flush_lat = 0, fmt_chg_cyc = 0;
   int hold_run = 0, last_hold = 0, hold_end_vs = 0, done_vs = 0;
   fmt_t fmt_seen = 3'd0;

   int cur_fmt = 0;
   int prev_req = 0;

   // Free-running VTG: vblank over the frame tail, a short vsync pulse inside it.
   initial begin
      logic vb_n, vs_n;
      vblank = 1'b0;
      vsync  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         fcnt = (fcnt + 1) % FRAME;
         vb_n = (fcnt >= VB_START);
         vs_n = (fcnt >= VS_START) && (fcnt < VS_START + VS_LEN);
         if (vb_n && !vblank) vb_rise_cyc = cyc;
         if (vs_n && !vsync)  vs_rise_cnt++;
         vblank = vb_n;
         vsync  = vs_n;
      end
   end

   // Event recorder sampled on the falling edge.
   always @(negedge clk) begin
      if (flush) begin
         n_flush++;
         flush_cyc = cyc;
         flush_lat = cyc - vb_rise_cyc;
      end
      if (fmt_def != fmt_seen) begin
         fmt_seen    = fmt_def;
         fmt_chg_cyc = cyc;
      end
      if (vtg_hold) hold_run++;
      else if (hold_run > 0) begin
         last_hold   = hold_run;
         hold_run    = 0;
         hold_end_vs = vs_rise_cnt;
      end
      if (sw_done) begin
         n_done++;
         done_vs = vs_rise_cnt;
      end
      if (sw_err)    n_err++;
      if (out_blank) n_blank++;
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      n_cmp++;
      if (observed !== expected) begin
         n_mis++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic waitFrameOffset(input int off);
      while (fcnt != off) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyStimulus(input int kind, input int c1, input int c2);
      waitFrameOffset(20);
      repeat ($urandom_range(0, 100)) @(posedge clk);
      #2;
      fmt_req = fmt_t'(c1);
      if (kind >= 2) begin
         repeat ($urandom_range(10, 50)) @(posedge clk);
         #2;
         fmt_req = fmt_t'(c2);
      end
   endtask

   function automatic int pickLegal(input int ex1, input int ex2);
      int c;
      do c = $urandom_range(0, MAX_LEGAL); while (c == ex1 || c == ex2);
      return c;
   endfunction

   // kind: 0 legal switch, 1 illegal code, 2 two legal codes before vblank, 3 change then revert.
   task automatic runCase(input int kind, input int c1, input int c2);
      int f0, d0, e0, b0, exp_fmt, exp_sw, exp_err;
      f0 = n_flush; d0 = n_done; e0 = n_err; b0 = n_blank;
      exp_fmt = cur_fmt; exp_sw = 0; exp_err = 0;
      case (kind)
         0: begin exp_fmt = c1; exp_sw = 1; end
         1: exp_err = (c1 != prev_req) ? 1 : 0;
         2: begin exp_fmt = c2; exp_sw = 1; end
         default: ;
      endcase
      applyStimulus(kind, c1, (kind == 3) ? cur_fmt : c2);
      repeat (3 * FRAME) @(posedge clk);
      @(negedge clk);
      checkOutput("fmt_def", fmt_def, exp_fmt);
      checkOutput("flush_count", n_flush - f0, exp_sw);
      checkOutput("done_count", n_done - d0, exp_sw);
      checkOutput("err_count", n_err - e0, exp_err);
      checkOutput("busy_idle", busy, 0);
      checkOutput("out_blank_idle", out_blank, 0);
      if (exp_sw == 1) begin
         checkOutput("flush_after_vblank", (flush_lat >= 1 && flush_lat <= 3) ? 1 : 0, 1);
         checkOutput("fmt_after_flush", fmt_chg_cyc - flush_cyc, 1);
         checkOutput("hold_len", last_hold, HOLD);
         checkOutput("settle_vsyncs", done_vs - hold_end_vs, SETTLE_N);
      end else begin
         checkOutput("no_blank_cycles", n_blank - b0, 0);
      end
      cur_fmt  = exp_fmt;
      prev_req = (kind == 3) ? cur_fmt : ((kind == 2) ? c2 : c1);
   endtask

   task automatic releaseAndInit();
      int v0;
      waitFrameOffset(10);
      rst = 1'b0;
      v0 = vs_rise_cnt;
      while (vs_rise_cnt == v0) begin @(posedge clk); #2; end
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("init_blank_after_vs1", out_blank, 1);
      checkOutput("init_hold_after_vs1", vtg_hold, 1);
      checkOutput("init_busy_after_vs1", busy, 1);
      while (vs_rise_cnt == v0 + 1) begin @(posedge clk); #2; end
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("init_blank_after_vs2", out_blank, 0);
      checkOutput("init_hold_after_vs2", vtg_hold, 0);
      checkOutput("init_busy_after_vs2", busy, 0);
      checkOutput("init_fmt_def", fmt_def, 0);
   endtask

   task automatic checkResetValues(input string pfx);
      checkOutput({pfx, "_fmt_def"}, fmt_def, 0);
      checkOutput({pfx, "_vtg_hold"}, vtg_hold, 1);
      checkOutput({pfx, "_out_blank"}, out_blank, 1);
      checkOutput({pfx, "_flush"}, flush, 0);
      checkOutput({pfx, "_busy"}, busy, 1);
      checkOutput({pfx, "_sw_done"}, sw_done, 0);
      checkOutput({pfx, "_sw_err"}, sw_err, 0);
   endtask

   initial begin
      int kind, c1, c2, f0, waited;
      rst     = 1'b1;
      fmt_req = 3'd0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkResetValues("rst");
      releaseAndInit();

      runCase(0, 2, 0);
      runCase(1, 7, 0);
      runCase(1, 7, 0);
      runCase(2, 4, 3);
      runCase(3, 1, 0);

      // Reset in the middle of APPLY.
      waitFrameOffset(20);
      f0 = n_flush;
      fmt_req = fmt_t'(pickLegal(cur_fmt, cur_fmt));
      waited = 0;
      while (n_flush == f0 && waited < 2 * FRAME) begin
         @(posedge clk);
         waited++;
      end
      checkOutput("apply_reached", (n_flush != f0) ? 1 : 0, 1);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkResetValues("midrst");
      fmt_req = 3'd0;
      repeat (3) @(posedge clk);
      releaseAndInit();
      cur_fmt  = 0;
      prev_req = 0;

      for (int i = 0; i < 8; i++) begin
         kind = $urandom_range(0, 3);
         c1 = 0;
         c2 = 0;
         case (kind)
            0, 3: c1 = pickLegal(cur_fmt, cur_fmt);
            1:    c1 = $urandom_range(MAX_LEGAL + 1, 7);
            default: begin
               c1 = pickLegal(cur_fmt, cur_fmt);
               c2 = pickLegal(cur_fmt, c1);
            end
         endcase
         runCase(kind, c1, c2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
